// File: rtl/lowbit_pkg.sv
// lowbit_pkg: elaboration-time helpers for the lowest-set-bit encoder.
//   lvls    - number of tree levels (clog2 of width, at least 1)
//   idx_off - bit offset of a tree level inside the flat index store
package lowbit_pkg;

  // Tree depth. A 1-bit input still gets one level so every index slice
  // is at least one bit wide.
  function automatic int lvls(input int w);
    int l;
    l = 0;
    while ((1 << l) < w) l++;
    return (l < 1) ? 1 : l;
  endfunction

  // Level lv holds (p >> lv) nodes, each with an lv-bit index. Levels are
  // packed back to back starting with level 1. Leaves carry no index.
  function automatic int idx_off(input int p, input int lv);
    int o;
    o = 0;
    for (int j = 1; j < lv; j++) o += (p >> j) * j;
    return o;
  endfunction

endpackage

// File: rtl/lowbit_merge.sv
// lowbit_merge: one 2-way node of the lowest-set-bit tree.
//   any_lo/idx_lo - result of the low half
//   any_hi/idx_hi - result of the high half
//   any_o/idx_o   - merged result, index one bit wider
// The low half wins when it has a set bit. Otherwise the high half is taken
// and the new index MSB is set -- but only if the high half has a set bit,
// so an all-zero subtree always reports index 0.
module lowbit_merge #(
  parameter int IW = 1
) (
  input  logic          any_lo,
  input  logic [IW-1:0] idx_lo,
  input  logic          any_hi,
  input  logic [IW-1:0] idx_hi,
  output logic          any_o,
  output logic [IW:0]   idx_o
);

  assign any_o = any_lo | any_hi;
  assign idx_o = any_lo ? {1'b0, idx_lo} : {any_hi, idx_hi};

endmodule

// File: rtl/lowbit.sv
// lowbit: parameterised lowest-set-bit (priority) encoder.
//   clk, rst - clock and synchronous active-high reset (registered outputs only)
//   in       - vector to search
//   out      - combinational index of the least-significant set bit (0 if none)
//   found    - combinational, 1 iff in != 0
//   out_q    - out registered on clk
//   found_q  - found registered on clk
// The input is zero-padded to a power of two and reduced by a balanced tree
// of lowbit_merge nodes. Nodes live in heap order in any_h (root at 1,
// leaves at P..2P-1); their indices live level by level in idx_f.
module lowbit
  import lowbit_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 found,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic                 found_q
);

  localparam int LVL  = lvls(IN_WIDTH);
  localparam int P    = 1 << LVL;
  localparam int IDXB = idx_off(P, LVL + 1);
  localparam int ROOT = IDXB - LVL;

  logic [2*P-1:1]  any_h;
  logic [IDXB-1:0] idx_f;
  logic [LVL-1:0]  root_idx;

  // Leaves, with zero padding above IN_WIDTH.
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < IN_WIDTH) begin : g_real
      assign any_h[P+i] = in[i];
    end else begin : g_pad
      assign any_h[P+i] = 1'b0;
    end
  end

  // First level merges raw bits directly; the index is 1 only when the
  // high bit alone is set.
  for (genvar k = 0; k < P/2; k++) begin : g_l1
    assign any_h[P/2+k] = any_h[P+2*k] | any_h[P+2*k+1];
    assign idx_f[k]     = any_h[P+2*k+1] & ~any_h[P+2*k];
  end

  // Remaining levels: level l merges pairs from level l-1.
  for (genvar l = 2; l <= LVL; l++) begin : g_lvl
    localparam int CB = P >> (l - 1);     // heap base of child level
    localparam int NB = P >> l;           // heap base of this level
    localparam int CO = idx_off(P, l - 1);
    localparam int NO = idx_off(P, l);
    for (genvar k = 0; k < (P >> l); k++) begin : g_node
      lowbit_merge #(.IW(l - 1)) u_merge (
        .any_lo (any_h[CB+2*k]),
        .idx_lo (idx_f[CO+(2*k)*(l-1) +: l-1]),
        .any_hi (any_h[CB+2*k+1]),
        .idx_hi (idx_f[CO+(2*k+1)*(l-1) +: l-1]),
        .any_o  (any_h[NB+k]),
        .idx_o  (idx_f[NO+k*l +: l])
      );
    end
  end

  assign root_idx = idx_f[ROOT +: LVL];
  assign found    = any_h[1];
  assign out      = OUT_WIDTH'(root_idx);

  // Registered copy for pipelined consumers.
  logic [OUT_WIDTH-1:0] res_d, res_q;
  logic                 fnd_d, fnd_q;

  assign res_d = out;
  assign fnd_d = found;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      fnd_q <= 1'b0;
    end else begin
      res_q <= res_d;
      fnd_q <= fnd_d;
    end
  end

  assign out_q   = res_q;
  assign found_q = fnd_q;

endmodule

// File: tb/tb_lowbit.sv
module tb_lowbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in32 = '0;
  logic [4:0]  out32, out32_q;
  logic        fnd32, fnd32_q;
  logic [4:0]  in5 = '0;
  logic [3:0]  out5, out5_q;
  logic        fnd5, fnd5_q;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lowbit #(.IN_WIDTH(32), .OUT_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .in(in32), .out(out32), .found(fnd32),
    .out_q(out32_q), .found_q(fnd32_q)
  );

  lowbit #(.IN_WIDTH(5), .OUT_WIDTH(4)) dut5 (
    .clk(clk), .rst(rst), .in(in5), .out(out5), .found(fnd5),
    .out_q(out5_q), .found_q(fnd5_q)
  );

  typedef struct {
    logic [31:0] vin;
    logic [4:0]  vout;
    logic        vfnd;
  } vec32_t;

  typedef struct {
    logic [4:0] vin;
    logic [3:0] vout;
    logic       vfnd;
  } vec5_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model(input logic [31:0] v);
    for (int i = 0; i < 32; i++)
      if (v[i]) return {1'b1, 5'(i)};
    return 6'd0;
  endfunction

  // Apply one vector, check the combinational path, then the registered one.
  task automatic apply32(input string name, input logic [31:0] v,
                         input logic [4:0] eo, input logic ef);
    @(negedge clk);
    in32 = v;
    #1;
    chk({name, ".out"}, 32'(out32), 32'(eo));
    chk({name, ".found"}, 32'(fnd32), 32'(ef));
    @(posedge clk);
    #1;
    chk({name, ".out_q"}, 32'(out32_q), 32'(eo));
    chk({name, ".found_q"}, 32'(fnd32_q), 32'(ef));
  endtask

  vec32_t t32[7];
  vec5_t  t5[6];

  initial begin
    logic [5:0]  m;
    logic [31:0] r;

    t32[0] = '{32'hFFFF_FFF8, 5'd3,  1'b1};
    t32[1] = '{32'h0000_0001, 5'd0,  1'b1};
    t32[2] = '{32'h0000_0000, 5'd0,  1'b0};
    t32[3] = '{32'h8000_0000, 5'd31, 1'b1};
    t32[4] = '{32'hFFFF_FFFF, 5'd0,  1'b1};
    t32[5] = '{32'h0000_000A, 5'd1,  1'b1};
    t32[6] = '{32'h0001_0000, 5'd16, 1'b1};

    t5[0] = '{5'b10100, 4'd2, 1'b1};
    t5[1] = '{5'b10000, 4'd4, 1'b1};
    t5[2] = '{5'b00000, 4'd0, 1'b0};
    t5[3] = '{5'b00001, 4'd0, 1'b1};
    t5[4] = '{5'b11111, 4'd0, 1'b1};
    t5[5] = '{5'b01000, 4'd3, 1'b1};

    // Reset state of the registered outputs.
    @(posedge clk);
    #1;
    chk("rst.out_q", 32'(out32_q), 32'd0);
    chk("rst.found_q", 32'(fnd32_q), 32'd0);
    chk("rst.out5_q", 32'(out5_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      apply32($sformatf("t32[%0d]", i), t32[i].vin, t32[i].vout, t32[i].vfnd);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in5 = t5[i].vin;
      #1;
      chk($sformatf("t5[%0d].out", i), 32'(out5), 32'(t5[i].vout));
      chk($sformatf("t5[%0d].found", i), 32'(fnd5), 32'(t5[i].vfnd));
      @(posedge clk);
      #1;
      chk($sformatf("t5[%0d].out_q", i), 32'(out5_q), 32'(t5[i].vout));
    end

    for (int k = 0; k < 32; k++) begin
      apply32($sformatf("walk1[%0d]", k), 32'd1 << k, 5'(k), 1'b1);
      apply32($sformatf("walkhi[%0d]", k), 32'hFFFF_FFFF << k, 5'(k), 1'b1);
    end

    for (int n = 0; n < 10000; n++) begin
      r = $urandom();
      // Thin out the vectors sometimes so high indices get exercised.
      if (n % 4 == 1) r = r & $urandom() & $urandom() & $urandom();
      if (n % 8 == 3) r = r & (32'hFFFF_FFFF << $urandom_range(31, 0));
      m = model(r);
      @(negedge clk);
      in32 = r;
      #1;
      chk("rand.out", 32'(out32), 32'(m[4:0]));
      chk("rand.found", 32'(fnd32), 32'(m[5]));
    end

    // Load a nonzero registered value, then reset mid-stream.
    apply32("pre_rst", 32'h0000_0100, 5'd8, 1'b1);
    @(negedge clk);
    rst  = 1'b1;
    in32 = 32'h0000_0010;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("inrst.out", 32'(out32), 32'd4);
      chk("inrst.found", 32'(fnd32), 32'd1);
      @(posedge clk);
      #1;
      chk("inrst.out_q", 32'(out32_q), 32'd0);
      chk("inrst.found_q", 32'(fnd32_q), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst.out_q", 32'(out32_q), 32'd4);
    chk("postrst.found_q", 32'(fnd32_q), 32'd1);

    // Registered path follows a new value every cycle.
    @(negedge clk);
    in32 = 32'h0000_0040;
    @(negedge clk);
    in32 = 32'h0000_0000;
    #1;
    chk("b2b.out_q", 32'(out32_q), 32'd6);
    chk("b2b.found_q", 32'(fnd32_q), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b.out_q0", 32'(out32_q), 32'd0);
    chk("b2b.found_q0", 32'(fnd32_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lowbit.md
Name: lowbit

Overview:
- Parameterised lowest-set-bit (priority) encoder.
- Returns the bit index of the least-significant '1' in a bit vector.
- Used by the graph-colouring read/write stage to pick the smallest free colour. That stage feeds it the complement of the used-colour bitmap and consumes `out` combinationally in the same cycle.
- A registered copy of the result plus a found flag is also provided for pipelined consumers.

Parameters:
- IN_WIDTH, default 32: width of the input vector. Must be >= 1.
- OUT_WIDTH, default 5: width of the index output. Must be >= clog2(IN_WIDTH); if larger, the extra upper bits are driven 0.

Ports:
- clk, input, 1: clock, used only by the registered outputs.
- rst, input, 1: reset, synchronous, active-high. Clears the registered outputs only.
- in, input, IN_WIDTH: vector to search.
- out, output, OUT_WIDTH: combinational index of the lowest set bit of `in`.
- found, output, 1: combinational; 1 iff `in` != 0.
- out_q, output, OUT_WIDTH: `out` registered on clk.
- found_q, output, 1: `found` registered on clk.

Behaviour:
Combinational path:
- `out` and `found` are purely combinational with zero latency. They settle within the same cycle as `in` and are independent of clk and rst.
- out = smallest i such that in[i] = 1.
- Higher set bits are ignored: in = 0b1010 gives out = 1.
- When in == 0: out = 0 and found = 0.
- Callers distinguish "no bit set" from "bit 0 set" via `found` or their own zero test. The colouring stage maps an all-ones bitmap to colour 32 itself.
- Implementation is a balanced log2 tree of 2-way merges. Each node outputs (any, idx): the low half wins if its `any` is set, otherwise the high half with the MSB of the index set.
- Inputs whose width is not a power of two are zero-padded up to the next power of two before the tree.
- The result is zero-extended or truncated to OUT_WIDTH. The truncation case is illegal per the parameter rule.
- No X propagation: every input bit pattern yields a defined output.

Registered path:
- On each rising clk edge, if rst = 1 then out_q <= 0 and found_q <= 0.
- Otherwise out_q <= out and found_q <= found.
- Latency is 1 cycle; a new value is accepted every cycle with no handshake.

Reset behaviour:
- Reset values: out_q = 0, found_q = 0.
- Combinational outputs have no reset value; they always reflect `in`.
- Reset asserted mid-stream clears the registered outputs on the next edge.
- The first post-reset edge with rst = 0 captures the current `in`.

Decomposition:
- No shared-package typedefs are needed; parameters are local.
- One natural sub-module: `lowbit_merge`. It combines two (any, idx) half-results into one, parameterised on index width, and is instantiated per tree level via generate loops.

Test Plan:
- IN_WIDTH=32, OUT_WIDTH=5, in = 0xFFFFFFF8 (complement of bitmap 0x7) -> out = 3, found = 1; the next cycle gives out_q = 3, found_q = 1.
- in = 0x00000001 -> out = 0, found = 1; in = 0x00000000 -> out = 0, found = 0.
- in = 0x80000000 -> out = 31; in = 0xFFFFFFFF -> out = 0.
- Walking-one (in = 1<<k for k = 0..31) and walking-one with all higher bits set -> out = k each time; plus 10k random vectors checked against a behavioural loop model.
- rst = 1 held for 2 cycles while in = 0x00000010: out = 4 combinationally; out_q = 0 and found_q = 0 during reset. The first edge after release gives out_q = 4, found_q = 1.
- IN_WIDTH=5, OUT_WIDTH=4, in = 5'b10100 -> out = 4'd2; in = 5'b10000 -> out = 4'd4 (non-power-of-two padding, upper index bit 0).
